// File: rtl/sobel_mdc_job_sequencer_pkg.sv
// Shared definitions for the Sobel/Roberts MDC job sequencer: FSM state
// encoding, register-file control/flag bundles and default sizing.
// The watchdog (SOBEL_MDC_SEQ_WATCHDOG_EN builds) uses SEQ_WDOG_CYCLES as its default.
package multi_dataflow_sobel_mdc_package;

    // Output-pel counter width: clog2(1024)+1, so a full 1024-beat frame fits.
    localparam int unsigned SEQ_CNT_W       = 11;
    localparam int unsigned SEQ_ITER_W      = 16;
    localparam int unsigned SEQ_WDOG_CYCLES = 4096;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_PREP     = 3'd1,
        SEQ_ARM      = 3'd2,
        SEQ_RUN      = 3'd3,
        SEQ_ITER_END = 3'd4,
        SEQ_DONE     = 3'd5
    } sobel_mdc_seq_state_t;

    // Job request as the register file presents it to the sequencer.
    typedef struct packed {
        logic                  start;
        logic [SEQ_ITER_W-1:0] nb_iter;
        logic [SEQ_CNT_W-1:0]  cnt_limit;
    } ctrl_seq_multi_dataflow_sobel_mdc_t;

    // Status the sequencer reports back to the register file.
    typedef struct packed {
        logic                  busy;
        logic                  done;
        logic                  error;
        logic [SEQ_ITER_W-1:0] iter;
    } flags_seq_multi_dataflow_sobel_mdc_t;

endpackage

// File: rtl/sobel_mdc_job_sequencer_done_tracker.sv
// Sticky done latches for the three streamer channels (in_pel, in_size,
// out_pel). all_done_o includes pulses arriving in the current cycle so the
// sequencer can leave RUN without waiting an extra cycle.
module sobel_mdc_done_tracker (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic capture_i,
    input  logic in_pel_done_i,
    input  logic in_size_done_i,
    input  logic out_pel_done_i,
    output logic all_done_o
);

    logic [2:0] done_q;
    logic [2:0] done_now;

    // Qualify incoming pulses: only pulses seen while capturing count.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        done_now = '0;
        if (capture_i) begin
            done_now = {out_pel_done_i, in_size_done_i, in_pel_done_i};
        end
    end

    // Accumulate done pulses until the next clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= '0;
        end else if (clear_i) begin
            done_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
            done_q <= done_q | done_now;
        end
    end

    assign all_done_o = &(done_q | done_now);

endmodule

// File: rtl/sobel_mdc_job_sequencer.sv
// Job sequencer for the Sobel/Roberts MDC HWPE engine. Takes a start from the
// register file, then per iteration clears the engine, waits for the three
// streamer channels to be ready, arms them together with the engine, and
// waits for all three done pulses plus the expected output-beat count.
// After the programmed number of iterations it emits a one-cycle done_o.
// Optional stall watchdog: define SOBEL_MDC_SEQ_WATCHDOG_EN.
module sobel_mdc_job_sequencer
    import multi_dataflow_sobel_mdc_package::*;
#(
    parameter int unsigned CNT_W       = SEQ_CNT_W,
    parameter int unsigned ITER_W      = SEQ_ITER_W
`ifdef SOBEL_MDC_SEQ_WATCHDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = SEQ_WDOG_CYCLES
`endif
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [ITER_W-1:0] nb_iter_i,
    input  logic [CNT_W-1:0]  cnt_limit_i,
    input  logic              in_pel_ready_i,
    input  logic              in_size_ready_i,
    input  logic              out_pel_ready_i,
    input  logic              in_pel_done_i,
    input  logic              in_size_done_i,
    input  logic              out_pel_done_i,
    input  logic [CNT_W-1:0]  eng_cnt_out_pel_i,
    output logic              in_pel_req_o,
    output logic              in_size_req_o,
    output logic              out_pel_req_o,
    output logic              eng_clear_o,
    output logic              eng_start_o,
    output logic              eng_enable_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              error_o
);

    sobel_mdc_seq_state_t state_q;

    logic [ITER_W-1:0] nb_iter_q;
    logic [CNT_W-1:0]  cnt_limit_q;
    logic [ITER_W-1:0] iter_q;
    logic              busy_q;
    logic              done_q;
    logic              eng_clear_q;
    logic              arm_q;
    logic              enable_q;

    logic all_ready;
    logic all_done;
    logic tracker_clear;
    logic iter_complete;

    assign all_ready     = in_pel_ready_i & in_size_ready_i & out_pel_ready_i;
    assign tracker_clear = clear_i | (state_q == SEQ_PREP);
    assign iter_complete = all_done & (eng_cnt_out_pel_i == cnt_limit_q);

    sobel_mdc_done_tracker u_done_tracker (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (tracker_clear),
        .capture_i      (state_q == SEQ_RUN),
        .in_pel_done_i  (in_pel_done_i),
        .in_size_done_i (in_size_done_i),
        .out_pel_done_i (out_pel_done_i),
        .all_done_o     (all_done)
    );

`ifdef SOBEL_MDC_SEQ_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_q;
    logic [CNT_W-1:0]  cnt_prev_q;
    logic              error_q;
    logic              stall_kick;
    logic              wdog_expired;

    // Any sign of progress restarts the stall window.
    assign stall_kick   = (eng_cnt_out_pel_i != cnt_prev_q) | in_pel_done_i
                        | in_size_done_i | out_pel_done_i;
    assign wdog_expired = ~stall_kick & (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

    // Stall counter: counts RUN cycles without progress, idle elsewhere.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q     <= '0;
            cnt_prev_q <= '0;
        end else begin
            cnt_prev_q <= eng_cnt_out_pel_i;
            if (clear_i || state_q != SEQ_RUN || stall_kick) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_q + WDOG_W'(1);
            end
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    // Job FSM; every output is a register set on the transition into its state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the latched job configuration is reset too, so nothing downstream ever sees X after reset.
            state_q     <= SEQ_IDLE;
            nb_iter_q   <= '0;
            cnt_limit_q <= '0;
            iter_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            eng_clear_q <= 1'b0;
            arm_q       <= 1'b0;
            enable_q    <= 1'b0;
`ifdef SOBEL_MDC_SEQ_WATCHDOG_EN
            error_q     <= 1'b0;
`endif
        end else if (clear_i) begin
            state_q     <= SEQ_IDLE;
            nb_iter_q   <= '0;
            cnt_limit_q <= '0;
            iter_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            eng_clear_q <= 1'b0;
            arm_q       <= 1'b0;
            enable_q    <= 1'b0;
`ifdef SOBEL_MDC_SEQ_WATCHDOG_EN
            error_q     <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; only the entering transition raises them.
            eng_clear_q <= 1'b0;
            arm_q       <= 1'b0;
            done_q      <= 1'b0;

            case (state_q)
                SEQ_IDLE: begin
                    if (start_i) begin
                        nb_iter_q   <= (nb_iter_i == '0) ? ITER_W'(1) : nb_iter_i;
                        cnt_limit_q <= cnt_limit_i;
                        iter_q      <= '0;
                        busy_q      <= 1'b1;
                        eng_clear_q <= 1'b1;
`ifdef SOBEL_MDC_SEQ_WATCHDOG_EN
                        error_q     <= 1'b0;
`endif
                        state_q     <= SEQ_PREP;
                    end
                end

                SEQ_PREP: begin
                    if (all_ready) begin
                        arm_q   <= 1'b1;
                        state_q <= SEQ_ARM;
                    end
                end

                SEQ_ARM: begin
                    enable_q <= 1'b1;
                    state_q  <= SEQ_RUN;
                end

                SEQ_RUN: begin
                    if (iter_complete) begin
                        enable_q <= 1'b0;
                        iter_q   <= iter_q + ITER_W'(1);
                        state_q  <= SEQ_ITER_END;
                    end
`ifdef SOBEL_MDC_SEQ_WATCHDOG_EN
                    else if (wdog_expired) begin
                        enable_q <= 1'b0;
                        error_q  <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= SEQ_DONE;
                    end
`endif
                end

                SEQ_ITER_END: begin
                    if (iter_q == nb_iter_q) begin
                        done_q  <= 1'b1;
                        state_q <= SEQ_DONE;
                    end else begin
                        eng_clear_q <= 1'b1;
                        state_q     <= SEQ_PREP;
                    end
                end

                SEQ_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= SEQ_IDLE;
                end

                default: begin
                    state_q <= SEQ_IDLE;
                end
            endcase
        end
    end

    assign in_pel_req_o  = arm_q;
    assign in_size_req_o = arm_q;
    assign out_pel_req_o = arm_q;
    assign eng_start_o   = arm_q;
    assign eng_clear_o   = eng_clear_q;
    assign eng_enable_o  = enable_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign iter_o        = iter_q;

endmodule
